wfg_wb_decoder: RTL and testbench

- Parametrised Wishbone classic slave decoder/mux for the waveform generator peripheral array.
- Sits between the Caravel user-area Wishbone port and NSLV peripheral register banks (core, interconnect, stimuli, drivers).
- Adds several capabilities: registered decode, one outstanding transaction, unmapped-page error, per-access timeout with error termination, and clean abort when cyc drops.
- Generalises the fixed 6-slave combinational select to N slaves with configurable page field.

---
 rtl/wfg_wb_pkg.sv | 33 +++
 rtl/wfg_wb_page_decode.sv | 41 ++++
 rtl/wfg_wb_decoder.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_wfg_wb_decoder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wfg_wb_pkg.sv
// -----------------------------------------------------------------------------
// wfg_wb_pkg
// Shared definitions for the waveform generator Wishbone decoder and any other
// bus master that reuses the page decoder.
//   wb_state_e     : decoder FSM states
//   WFG_BASE       : default value of the top address nibble
//   WFG_PAGE_LSB   : default lowest bit of the page field
//   WFG_ERR_DATA   : read data returned on an error termination
//   WFG_STAT_W     : width of each statistics counter
//   wfg_sat_inc    : saturating increment for the statistics counters
// -----------------------------------------------------------------------------
package wfg_wb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2
  } wb_state_e;

  localparam logic [3:0]  WFG_BASE     = 4'h3;
  localparam int          WFG_PAGE_LSB = 4;
  localparam logic [31:0] WFG_ERR_DATA = 32'hDEAD_BEEF;
  localparam int          WFG_STAT_W   = 16;

  function automatic logic [WFG_STAT_W-1:0] wfg_sat_inc(input logic [WFG_STAT_W-1:0] v);
    if (&v) begin
      wfg_sat_inc = v;
    end else begin
      wfg_sat_inc = v + WFG_STAT_W'(1);
    end
  endfunction

endpackage

// File: rtl/wfg_wb_page_decode.sv
// -----------------------------------------------------------------------------
// wfg_wb_page_decode
// Combinational address decoder: checks the base nibble and turns the page
// field into a one-hot select. Select bit i corresponds to page FIRST_PAGE+i,
// so a caller that maps page 0 passes FIRST_PAGE=0, otherwise FIRST_PAGE=1.
// Ports:
//   adr  in  [BUSW-1:PAGE_LSB]  upper address bits (base nibble + page field)
//   sel  out [NSEL-1:0]         one-hot page select, zero on miss
//   hit  out 1                  any select bit set
// -----------------------------------------------------------------------------
module wfg_wb_page_decode
  import wfg_wb_pkg::*;
#(
  parameter int         BUSW       = 32,
  parameter int         NSEL       = 6,
  parameter int         FIRST_PAGE = 1,
  parameter logic [3:0] BASE       = WFG_BASE,
  parameter int         PAGE_LSB   = WFG_PAGE_LSB
) (
  input  logic [BUSW-1:PAGE_LSB] adr,
  output logic [NSEL-1:0]        sel,
  output logic                   hit
);

  localparam int PAGEW = BUSW - 4 - PAGE_LSB;

  logic             base_ok;
  logic [PAGEW-1:0] page;

  assign base_ok = (adr[BUSW-1:BUSW-4] == BASE);
  assign page    = adr[BUSW-5:PAGE_LSB];

  generate
    for (genvar gi = 0; gi < NSEL; gi++) begin : g_sel
      assign sel[gi] = base_ok && (page == PAGEW'(gi + FIRST_PAGE));
    end
  endgenerate

  assign hit = |sel;

endmodule

// File: rtl/wfg_wb_decoder.sv
// -----------------------------------------------------------------------------
// wfg_wb_decoder
// Wishbone classic slave decoder/mux for the waveform generator peripherals.
// One request is outstanding at a time. The request is decoded and latched in
// IDLE, the selected slave is strobed in ACTIVE, and RESP carries exactly one
// cycle of ack or err back to the host. A slave that never acks is cut off
// after TIMEOUT cycles with err; the host dropping cyc aborts silently.
//
// Optional build macro WFG_WB_DECODER_STATS_EN: page 0 becomes a read-only
// statistics register ({timeout count, unmapped count}, 16-bit saturating
// each); a write to page 0 clears both counters. Without the macro page 0 is
// unmapped like any other page outside 1..NSLV.
//
// Ports:
//   io_wbs_clk, io_wbs_rst_n   clock, asynchronous active-low reset
//   io_wbs_adr/datwr/we/stb/cyc host request
//   io_wbs_datrd/ack/err       host response (ack/err are one-cycle pulses)
//   s_stb_o [NSLV]             one-hot slave strobe
//   s_cyc_o, s_we_o            slave cycle and latched write enable
//   s_adr_o [LADRW]            latched local address
//   s_dat_o [BUSW]             latched write data
//   s_dat_i [NSLV*BUSW]        slave read data, slave i at [i*BUSW +: BUSW]
//   s_ack_i [NSLV]             slave acks
// -----------------------------------------------------------------------------
module wfg_wb_decoder
  import wfg_wb_pkg::*;
#(
  parameter int              BUSW     = 32,
  parameter int              NSLV     = 6,
  parameter logic [3:0]      BASE     = WFG_BASE,
  parameter int              PAGE_LSB = WFG_PAGE_LSB,
  parameter int              LADRW    = 4,
  parameter int              TIMEOUT  = 255,
  parameter logic [BUSW-1:0] ERR_DATA = BUSW'(WFG_ERR_DATA)
) (
  input  logic                 io_wbs_clk,
  input  logic                 io_wbs_rst_n,
  input  logic [BUSW-1:0]      io_wbs_adr,
  input  logic [BUSW-1:0]      io_wbs_datwr,
  output logic [BUSW-1:0]      io_wbs_datrd,
  input  logic                 io_wbs_we,
  input  logic                 io_wbs_stb,
  input  logic                 io_wbs_cyc,
  output logic                 io_wbs_ack,
  output logic                 io_wbs_err,
  output logic [NSLV-1:0]      s_stb_o,
  output logic                 s_cyc_o,
  output logic                 s_we_o,
  output logic [LADRW-1:0]     s_adr_o,
  output logic [BUSW-1:0]      s_dat_o,
  input  logic [NSLV*BUSW-1:0] s_dat_i,
  input  logic [NSLV-1:0]      s_ack_i
);

  localparam int CNTW = $clog2(TIMEOUT + 1);

`ifdef WFG_WB_DECODER_STATS_EN
  localparam int NDEC       = NSLV + 1;
  localparam int FIRST_PAGE = 0;
`else
  localparam int NDEC       = NSLV;
  localparam int FIRST_PAGE = 1;
`endif

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [NDEC-1:0] dec_sel;
  logic            dec_hit;
  logic [NSLV-1:0] slv_sel;

  wfg_wb_page_decode #(
    .BUSW       (BUSW),
    .NSEL       (NDEC),
    .FIRST_PAGE (FIRST_PAGE),
    .BASE       (BASE),
    .PAGE_LSB   (PAGE_LSB)
  ) u_page_decode (
    .adr (io_wbs_adr[BUSW-1:PAGE_LSB]),
    .sel (dec_sel),
    .hit (dec_hit)
  );

  // The top NSLV select bits always belong to the real slaves (pages 1..NSLV).
  assign slv_sel = dec_sel[NDEC-1:NDEC-NSLV];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  wb_state_e       state_q, state_d;
  logic [NSLV-1:0] sel_q, sel_d;
  logic            miss_q, miss_d;
  logic [NSLV-1:0] s_stb_q, s_stb_d;
  logic            s_cyc_q, s_cyc_d;
  logic            we_q, we_d;
  logic [LADRW-1:0] adr_q, adr_d;
  logic [BUSW-1:0] wdat_q, wdat_d;
  logic [BUSW-1:0] datrd_q, datrd_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [CNTW-1:0] cnt_inc;
  logic            ack_hit;
  logic [BUSW-1:0] rd_mux;

  assign cnt_inc = cnt_q + CNTW'(1);

  // Only the latched slave may terminate the access; other acks are ignored.
  assign ack_hit = |(s_ack_i & sel_q);

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_q[i]) begin
        rd_mux = rd_mux | s_dat_i[i*BUSW +: BUSW];
      end
    end
  end

`ifdef WFG_WB_DECODER_STATS_EN
  logic                  stats_sel_q, stats_sel_d;
  logic [WFG_STAT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [WFG_STAT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic                  tmo_evt, miss_evt, stats_clr;
  logic [BUSW-1:0]       stats_rd;

  assign stats_rd = (adr_q == '0) ? BUSW'({tmo_cnt_q, miss_cnt_q}) : '0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    miss_d  = miss_q;
    s_stb_d = s_stb_q;
    s_cyc_d = s_cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    datrd_d = datrd_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
`ifdef WFG_WB_DECODER_STATS_EN
    stats_sel_d = stats_sel_q;
    tmo_evt     = 1'b0;
    miss_evt    = 1'b0;
    stats_clr   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (io_wbs_cyc && io_wbs_stb) begin
          // Every request spends at least one cycle in ACTIVE, so unmapped
          // accesses terminate with the same two-cycle latency as a slave
          // that acks immediately.
          sel_d   = slv_sel;
          miss_d  = !dec_hit;
          s_stb_d = slv_sel;
          s_cyc_d = |slv_sel;
          we_d    = io_wbs_we;
          adr_d   = io_wbs_adr[LADRW-1:0];
          wdat_d  = io_wbs_datwr;
          cnt_d   = '0;
          state_d = ACTIVE;
`ifdef WFG_WB_DECODER_STATS_EN
          stats_sel_d = dec_sel[0];
`endif
        end
      end

      ACTIVE: begin
        if (!io_wbs_cyc) begin
          // Host abandoned the cycle: release the slave, no termination.
          s_stb_d = '0;
          s_cyc_d = 1'b0;
          state_d = IDLE;
        end else if (miss_q) begin
          err_d   = 1'b1;
          datrd_d = ERR_DATA;
          state_d = RESP;
`ifdef WFG_WB_DECODER_STATS_EN
          miss_evt = 1'b1;
`endif
        end
`ifdef WFG_WB_DECODER_STATS_EN
        else if (stats_sel_q) begin
          ack_d     = 1'b1;
          datrd_d   = we_q ? '0 : stats_rd;
          stats_clr = we_q;
          state_d   = RESP;
        end
`endif
        else begin
          cnt_d = cnt_inc;
          // Ack is tested first so it wins over a coincident timeout.
          if (ack_hit) begin
            ack_d   = 1'b1;
            datrd_d = we_q ? '0 : rd_mux;
            s_stb_d = '0;
            s_cyc_d = 1'b0;
            state_d = RESP;
          end else if (cnt_inc == CNTW'(TIMEOUT)) begin
            err_d   = 1'b1;
            datrd_d = ERR_DATA;
            s_stb_d = '0;
            s_cyc_d = 1'b0;
            state_d = RESP;
`ifdef WFG_WB_DECODER_STATS_EN
            tmo_evt = 1'b1;
`endif
          end
        end
      end

      RESP: begin
        // The termination pulse is visible this cycle; stb is not sampled.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
    if (!io_wbs_rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      miss_q  <= 1'b0;
      s_stb_q <= '0;
      s_cyc_q <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= '0;
      datrd_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      miss_q  <= miss_d;
      s_stb_q <= s_stb_d;
      s_cyc_q <= s_cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      datrd_q <= datrd_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef WFG_WB_DECODER_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics counters
  // ---------------------------------------------------------------------------
  always_comb begin
    tmo_cnt_d  = tmo_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (stats_clr) begin
      tmo_cnt_d  = '0;
      miss_cnt_d = '0;
    end else begin
      if (tmo_evt) begin
        tmo_cnt_d = wfg_sat_inc(tmo_cnt_q);
      end
      if (miss_evt) begin
        miss_cnt_d = wfg_sat_inc(miss_cnt_q);
      end
    end
  end

  always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
    if (!io_wbs_rst_n) begin
      stats_sel_q <= 1'b0;
      tmo_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      stats_sel_q <= stats_sel_d;
      tmo_cnt_q   <= tmo_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign io_wbs_datrd = datrd_q;
  assign io_wbs_ack   = ack_q;
  assign io_wbs_err   = err_q;
  assign s_stb_o      = s_stb_q;
  assign s_cyc_o      = s_cyc_q;
  assign s_we_o       = we_q;
  assign s_adr_o      = adr_q;
  assign s_dat_o      = wdat_q;

endmodule

// File: tb/tb_wfg_wb_decoder.sv
// -----------------------------------------------------------------------------
// tb_wfg_wb_decoder
// Self-checking bench for wfg_wb_decoder (TIMEOUT=8). Expected host responses
// are queued when a request is driven and compared when ack/err appears.
// Build with +define+WFG_WB_DECODER_STATS_EN to exercise the statistics page.
// -----------------------------------------------------------------------------
module tb_wfg_wb_decoder;

  localparam int BUSW = 32;
  localparam int NSLV = 6;
  localparam int TMO  = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [BUSW-1:0]      io_wbs_adr;
  logic [BUSW-1:0]      io_wbs_datwr;
  logic [BUSW-1:0]      io_wbs_datrd;
  logic                 io_wbs_we;
  logic                 io_wbs_stb;
  logic                 io_wbs_cyc;
  logic                 io_wbs_ack;
  logic                 io_wbs_err;
  logic [NSLV-1:0]      s_stb_o;
  logic                 s_cyc_o;
  logic                 s_we_o;
  logic [3:0]           s_adr_o;
  logic [BUSW-1:0]      s_dat_o;
  logic [NSLV*BUSW-1:0] s_dat_i;
  logic [NSLV-1:0]      s_ack_i;

  always #5 clk = ~clk;

  wfg_wb_decoder #(
    .BUSW    (BUSW),
    .NSLV    (NSLV),
    .TIMEOUT (TMO)
  ) dut (
    .io_wbs_clk   (clk),
    .io_wbs_rst_n (rst_n),
    .io_wbs_adr   (io_wbs_adr),
    .io_wbs_datwr (io_wbs_datwr),
    .io_wbs_datrd (io_wbs_datrd),
    .io_wbs_we    (io_wbs_we),
    .io_wbs_stb   (io_wbs_stb),
    .io_wbs_cyc   (io_wbs_cyc),
    .io_wbs_ack   (io_wbs_ack),
    .io_wbs_err   (io_wbs_err),
    .s_stb_o      (s_stb_o),
    .s_cyc_o      (s_cyc_o),
    .s_we_o       (s_we_o),
    .s_adr_o      (s_adr_o),
    .s_dat_o      (s_dat_o),
    .s_dat_i      (s_dat_i),
    .s_ack_i      (s_ack_i)
  );

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_exp;
  int   n_checks = 0;
  int   n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference decode: base 3, page p in 1..NSLV strobes slave p-1.
  function automatic logic [NSLV-1:0] exp_sel(input logic [31:0] a);
    logic [23:0]     pg;
    logic [NSLV-1:0] one;
    pg      = a[27:4];
    one     = 1;
    exp_sel = '0;
    if (a[31:28] == 4'h3 && pg >= 24'd1 && pg <= 24'(NSLV)) begin
      exp_sel = one << (pg - 24'd1);
    end
  endfunction

  // Response monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && (io_wbs_ack || io_wbs_err)) begin
      check("ack_err_excl", {31'd0, io_wbs_ack & io_wbs_err}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rsp_err", {31'd0, io_wbs_err}, {31'd0, mon_exp.err});
        check("rsp_data", io_wbs_datrd, mon_exp.data);
        $display("rsp %s datrd=%h", io_wbs_err ? "err" : "ack", io_wbs_datrd);
      end
    end
  end

  // One host transaction. Slave ack_slv (or none if <0) acks ack_dly cycles
  // after its strobe with rdat; slaves in noise ack continuously.
  task automatic xfer(input string name, input logic [31:0] adr, input logic we_i,
                      input logic [31:0] wdat, input int ack_slv, input int ack_dly,
                      input logic [31:0] rdat, input logic [NSLV-1:0] noise,
                      input logic exp_err, input logic [31:0] exp_dat,
                      input int exp_lat, input int exp_stb_cyc);
    logic [NSLV-1:0] esel;
    int              lat;
    int              stb_hi;
    rsp_t            r;
    esel   = exp_sel(adr);
    lat    = -1;
    stb_hi = 0;
    r.err  = exp_err;
    r.data = exp_dat;
    exp_q.push_back(r);
    $display("req %s adr=%h we=%0d", name, adr, we_i);
    @(negedge clk);
    io_wbs_adr   = adr;
    io_wbs_we    = we_i;
    io_wbs_datwr = wdat;
    io_wbs_stb   = 1'b1;
    io_wbs_cyc   = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check({name, "/s_stb"}, 32'(s_stb_o), 32'(esel));
        check({name, "/s_cyc"}, {31'd0, s_cyc_o}, {31'd0, esel != '0});
        if (esel != '0) begin
          check({name, "/s_adr"}, {28'd0, s_adr_o}, {28'd0, adr[3:0]});
          check({name, "/s_we"}, {31'd0, s_we_o}, {31'd0, we_i});
          if (we_i) check({name, "/s_dat"}, s_dat_o, wdat);
        end
      end
      if (s_stb_o != '0) stb_hi++;
      if (io_wbs_ack || io_wbs_err) begin
        lat = n;
        break;
      end
      s_ack_i = noise;
      if (ack_slv >= 0 && n == 1 + ack_dly) begin
        s_ack_i[ack_slv]               = 1'b1;
        s_dat_i[ack_slv*BUSW +: BUSW] = rdat;
      end
    end
    io_wbs_stb = 1'b0;
    io_wbs_cyc = 1'b0;
    s_ack_i    = '0;
    check({name, "/latency"}, lat, exp_lat);
    check({name, "/stb_cycles"}, stb_hi, exp_stb_cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic        w;

    rst_n        = 1'b0;
    io_wbs_adr   = '0;
    io_wbs_datwr = '0;
    io_wbs_we    = 1'b0;
    io_wbs_stb   = 1'b0;
    io_wbs_cyc   = 1'b0;
    s_ack_i      = '0;
    for (int i = 0; i < NSLV; i++) s_dat_i[i*BUSW +: BUSW] = 32'hC0DE_0000 | 32'(i);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst/ack", {31'd0, io_wbs_ack}, 32'd0);
    check("rst/err", {31'd0, io_wbs_err}, 32'd0);
    check("rst/datrd", io_wbs_datrd, 32'd0);
    check("rst/s_stb", 32'(s_stb_o), 32'd0);
    check("rst/s_cyc", {31'd0, s_cyc_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Read slave 1, ack 2 cycles after its strobe
    xfer("rd_s1", 32'h3000_0024, 1'b0, 32'd0, 1, 2, 32'h1234_5678, '0,
         1'b0, 32'h1234_5678, 4, 3);
    // Write slave 2, immediate ack; writes return 0
    xfer("wr_s2", 32'h3000_0030, 1'b1, 32'hA5A5_A5A5, 2, 0, 32'hFFFF_0000, '0,
         1'b0, 32'h0000_0000, 2, 1);
`ifndef WFG_WB_DECODER_STATS_EN
    xfer("null_page", 32'h3000_0000, 1'b0, 32'd0, -1, 0, 32'd0, '0,
         1'b1, 32'hDEAD_BEEF, 2, 0);
`endif
    xfer("bad_base", 32'h4000_0010, 1'b0, 32'd0, -1, 0, 32'd0, '0,
         1'b1, 32'hDEAD_BEEF, 2, 0);
    xfer("page7", 32'h3000_0070, 1'b1, 32'h1111_2222, -1, 0, 32'd0, '0,
         1'b1, 32'hDEAD_BEEF, 2, 0);
    // Timeout on slave 3 while slave 0 acks continuously
    xfer("timeout", 32'h3000_0048, 1'b0, 32'd0, -1, 0, 32'd0, 6'b000001,
         1'b1, 32'hDEAD_BEEF, TMO + 1, TMO);

    // Sweep all slaves with varying ack delay and direction
    for (int i = 0; i < NSLV; i++) begin
      a = 32'h3000_0000 | (32'(i + 1) << 4) | 32'(i + 3);
      d = $urandom;
      w = (i % 2) == 1;
      xfer($sformatf("sweep%0d", i), a, w, ~d, i, i % 3, d, '0,
           1'b0, w ? 32'd0 : d, 2 + (i % 3), 1 + (i % 3));
    end

    // Host drops cyc three cycles into ACTIVE
    $display("req abort adr=30000058");
    @(negedge clk);
    io_wbs_adr = 32'h3000_0058;
    io_wbs_we  = 1'b0;
    io_wbs_stb = 1'b1;
    io_wbs_cyc = 1'b1;
    @(negedge clk);
    check("abort/s_stb_on", 32'(s_stb_o), 32'h10);
    repeat (2) @(negedge clk);
    io_wbs_stb = 1'b0;
    io_wbs_cyc = 1'b0;
    @(negedge clk);
    check("abort/s_stb_off", 32'(s_stb_o), 32'd0);
    check("abort/s_cyc_off", {31'd0, s_cyc_o}, 32'd0);
    repeat (3) @(negedge clk);

    xfer("post_abort", 32'h3000_0015, 1'b0, 32'd0, 0, 1, 32'h0BAD_CAFE, '0,
         1'b0, 32'h0BAD_CAFE, 3, 2);

    // Asynchronous reset in the middle of ACTIVE
    $display("req reset_mid adr=30000017");
    @(negedge clk);
    io_wbs_adr   = 32'h3000_0017;
    io_wbs_we    = 1'b1;
    io_wbs_datwr = 32'h5A5A_1234;
    io_wbs_stb   = 1'b1;
    io_wbs_cyc   = 1'b1;
    @(negedge clk);
    check("rstmid/s_stb_on", 32'(s_stb_o), 32'h01);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid/s_stb", 32'(s_stb_o), 32'd0);
    check("rstmid/s_cyc", {31'd0, s_cyc_o}, 32'd0);
    check("rstmid/s_we", {31'd0, s_we_o}, 32'd0);
    check("rstmid/s_adr", {28'd0, s_adr_o}, 32'd0);
    check("rstmid/s_dat", s_dat_o, 32'd0);
    check("rstmid/datrd", io_wbs_datrd, 32'd0);
    check("rstmid/ack_err", {30'd0, io_wbs_ack, io_wbs_err}, 32'd0);
    io_wbs_stb = 1'b0;
    io_wbs_cyc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef WFG_WB_DECODER_STATS_EN
    // Counters were cleared by the reset above
    xfer("st_tmo1", 32'h3000_0020, 1'b0, 32'd0, -1, 0, 32'd0, '0,
         1'b1, 32'hDEAD_BEEF, TMO + 1, TMO);
    xfer("st_tmo2", 32'h3000_0060, 1'b1, 32'h7777_7777, -1, 0, 32'd0, '0,
         1'b1, 32'hDEAD_BEEF, TMO + 1, TMO);
    xfer("st_miss", 32'h4000_0010, 1'b0, 32'd0, -1, 0, 32'd0, '0,
         1'b1, 32'hDEAD_BEEF, 2, 0);
    xfer("st_read", 32'h3000_0000, 1'b0, 32'd0, -1, 0, 32'd0, '0,
         1'b0, 32'h0002_0001, 2, 0);
    xfer("st_clear", 32'h3000_0000, 1'b1, 32'hFFFF_FFFF, -1, 0, 32'd0, '0,
         1'b0, 32'h0000_0000, 2, 0);
    xfer("st_reread", 32'h3000_0000, 1'b0, 32'd0, -1, 0, 32'd0, '0,
         1'b0, 32'h0000_0000, 2, 0);
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
